// File: rtl/blit_memarb_pkg.sv
// Shared types and constants for the blitter memory-port arbiter.
// Holds the FSM encoding, the bus widths and the saturating grant-streak helper.
package blit_pkg;

    localparam int ADDR_W       = 18;
    localparam int DATA_W       = 16;
    localparam int DISP_MAX_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DISP = 2'd1,
        ST_CPU  = 2'd2
    } arb_state_e;

    // Count one more display grant, holding at the limit.
    function automatic logic [3:0] streak_inc(input logic [3:0] cur, input logic [3:0] lim);
        logic [3:0] res;
        if (cur >= lim) begin
            res = lim;
        end else begin
            res = cur + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/blit_memarb_if.sv
// Bundle of the display, CPU and memory-controller handshakes around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface blit_memarb_if;
    import blit_pkg::*;

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_ack;
    logic [DATA_W-1:0] disp_rdata;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [1:0]        cpu_wstrb;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_wstrb;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        input  mem_ack, mem_rdata,
        output disp_ack, disp_rdata, cpu_ack, cpu_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        output mem_ack, mem_rdata,
        input  disp_ack, disp_rdata, cpu_ack, cpu_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

endinterface

// File: rtl/blit_memarb.sv
// Two-requester arbiter for the shared 16-bit memory port: display has priority,
// but after DISP_MAX consecutive display grants with the CPU waiting, the CPU gets a turn.
module blit_memarb
    import blit_pkg::*;
#(
    parameter int DISP_MAX = DISP_MAX_DEF
) (
    input  logic         clk,
    input  logic         rst,
    blit_memarb_if.slave bus
);

    localparam logic [3:0] STREAK_LIM = 4'(DISP_MAX);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;

    logic              dp_pend_r;
    logic [ADDR_W-1:0] dp_addr_r;
    logic [3:0]        streak_r;

    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [1:0]        mem_wstrb_r;
    logic              disp_ack_r;
    logic [DATA_W-1:0] disp_rdata_r;
    logic              cpu_ack_r;
    logic [DATA_W-1:0] cpu_rdata_r;

    logic              disp_valid_s;
    logic              cpu_turn_s;
    logic [ADDR_W-1:0] disp_addr_sel_s;
    logic              grant_disp_s;
    logic              grant_cpu_s;
    logic              done_s;

    // A fresh pulse bypasses the latch so an idle port is granted without an extra cycle.
    assign disp_valid_s    = dp_pend_r | bus.disp_req;
    assign disp_addr_sel_s = bus.disp_req ? bus.disp_addr : dp_addr_r;
    assign cpu_turn_s      = bus.cpu_req & (streak_r == STREAK_LIM);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, grant selection and transaction completion
    always_comb begin
        state_nxt_s  = state_r;
        grant_disp_s = 1'b0;
        grant_cpu_s  = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (disp_valid_s && !cpu_turn_s) begin
                    grant_disp_s = 1'b1;
                    state_nxt_s  = ST_DISP;
                end else if (bus.cpu_req) begin
                    grant_cpu_s = 1'b1;
                    state_nxt_s = ST_CPU;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DISP, ST_CPU: begin
                if (bus.mem_ack) begin
                    done_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // One-deep display request latch; a pulse while pending overwrites the address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_pend_r <= 1'b0;
            dp_addr_r <= '0;
        end else if (grant_disp_s) begin
            dp_pend_r <= 1'b0;
        end else if (bus.disp_req) begin
            dp_pend_r <= 1'b1;
            dp_addr_r <= bus.disp_addr;
        end else begin
            dp_pend_r <= dp_pend_r;
        end
    end

    // Consecutive display grants counted only while the CPU is waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_r <= 4'd0;
        end else if (grant_disp_s) begin
            streak_r <= bus.cpu_req ? streak_inc(streak_r, STREAK_LIM) : 4'd0;
        end else if (grant_cpu_s) begin
            streak_r <= 4'd0;
        end else begin
            streak_r <= streak_r;
        end
    end

    // Memory command issue, read-data capture and requester ack pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            mem_wstrb_r  <= 2'b00;
            disp_ack_r   <= 1'b0;
            disp_rdata_r <= '0;
            cpu_ack_r    <= 1'b0;
            cpu_rdata_r  <= '0;
        end else begin
            disp_ack_r <= done_s && (state_r == ST_DISP);
            cpu_ack_r  <= done_s && (state_r == ST_CPU);
            if (done_s) begin
                mem_req_r <= 1'b0;
                if (state_r == ST_DISP) begin
                    disp_rdata_r <= bus.mem_rdata;
                end else if (!mem_we_r) begin
                    cpu_rdata_r <= bus.mem_rdata;
                end else begin
                    cpu_rdata_r <= cpu_rdata_r;
                end
            end else if (grant_disp_s) begin
                mem_req_r   <= 1'b1;
                mem_we_r    <= 1'b0;
                mem_addr_r  <= disp_addr_sel_s;
                mem_wdata_r <= '0;
                mem_wstrb_r <= 2'b11;
            end else if (grant_cpu_s) begin
                mem_req_r   <= 1'b1;
                mem_we_r    <= bus.cpu_we;
                mem_addr_r  <= bus.cpu_addr;
                mem_wdata_r <= bus.cpu_wdata;
                mem_wstrb_r <= bus.cpu_wstrb;
            end else begin
                mem_req_r <= mem_req_r;
            end
        end
    end

    assign bus.mem_req    = mem_req_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.mem_wstrb  = mem_wstrb_r;
    assign bus.disp_ack   = disp_ack_r;
    assign bus.disp_rdata = disp_rdata_r;
    assign bus.cpu_ack    = cpu_ack_r;
    assign bus.cpu_rdata  = cpu_rdata_r;

endmodule

// File: tb/tb_blit_memarb.sv
// Bench for blit_memarb: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level model of the arbitration rules.
module tb_blit_memarb;
    import blit_pkg::*;

    localparam int DMAX = 4;

    logic clk;
    logic rst;
    blit_memarb_if bus();

    blit_memarb #(.DISP_MAX(DMAX)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // memory responder settings
    int          fix_lat   = -1;
    bit          fix_rd_en = 1'b0;
    logic [15:0] fix_rd    = 16'h0000;
    bit          mbusy     = 1'b0;
    int          mwait     = 0;

    // model: who owns the port (0 none, 1 display, 2 cpu), waiting display, streak
    int          m_owner;
    bit          m_pend;
    logic [17:0] m_paddr;
    int          m_streak;
    logic        e_mem_req, e_we, e_disp_ack, e_cpu_ack;
    logic [17:0] e_addr;
    logic [15:0] e_wdata, e_disp_rdata, e_cpu_rdata;
    logic [1:0]  e_wstrb;

    int seq [6];
    int nseq;
    int n;
    bit d_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_owner = 0; m_pend = 1'b0; m_paddr = 18'h0; m_streak = 0;
        e_mem_req = 1'b0; e_we = 1'b0; e_disp_ack = 1'b0; e_cpu_ack = 1'b0;
        e_addr = 18'h0; e_wdata = 16'h0; e_wstrb = 2'b00;
        e_disp_rdata = 16'h0; e_cpu_rdata = 16'h0;
    endtask

    // Advance the model by one cycle using the inputs presented this cycle.
    task automatic model_step();
        bit          disp_wants;
        bit          cpu_turn;
        logic [17:0] newest;
        e_disp_ack = 1'b0;
        e_cpu_ack  = 1'b0;
        if (m_owner != 0) begin
            if (bus.mem_ack) begin
                e_mem_req = 1'b0;
                if (m_owner == 1) begin
                    e_disp_ack = 1'b1; e_disp_rdata = bus.mem_rdata;
                end else begin
                    e_cpu_ack = 1'b1;
                    if (!e_we) e_cpu_rdata = bus.mem_rdata;
                end
                m_owner = 0;
            end
            if (bus.disp_req) begin m_pend = 1'b1; m_paddr = bus.disp_addr; end
        end else begin
            disp_wants = m_pend || bus.disp_req;
            newest     = bus.disp_req ? bus.disp_addr : m_paddr;
            cpu_turn   = bus.cpu_req && (m_streak >= DMAX);
            if (disp_wants && !cpu_turn) begin
                m_owner = 1; m_pend = 1'b0;
                e_mem_req = 1'b1; e_we = 1'b0; e_addr = newest; e_wstrb = 2'b11;
                if (bus.cpu_req) m_streak = (m_streak + 1 > DMAX) ? DMAX : m_streak + 1;
                else m_streak = 0;
            end else if (bus.cpu_req) begin
                m_owner = 2; m_streak = 0;
                e_mem_req = 1'b1; e_we = bus.cpu_we; e_addr = bus.cpu_addr;
                e_wdata = bus.cpu_wdata; e_wstrb = bus.cpu_wstrb;
                if (bus.disp_req) begin m_pend = 1'b1; m_paddr = bus.disp_addr; end
            end
        end
    endtask

    task automatic compare();
        check("mem_req", 32'(bus.mem_req), 32'(e_mem_req));
        if (e_mem_req) begin
            check("mem_we", 32'(bus.mem_we), 32'(e_we));
            check("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
            check("mem_wstrb", 32'(bus.mem_wstrb), 32'(e_wstrb));
            if (e_we) check("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
        end
        check("disp_ack", 32'(bus.disp_ack), 32'(e_disp_ack));
        check("cpu_ack", 32'(bus.cpu_ack), 32'(e_cpu_ack));
        check("disp_rdata", 32'(bus.disp_rdata), 32'(e_disp_rdata));
        check("cpu_rdata", 32'(bus.cpu_rdata), 32'(e_cpu_rdata));
    endtask

    task automatic mem_respond();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'($urandom);
        if (bus.mem_req && !mbusy) begin
            mbusy = 1'b1;
            mwait = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
        end
        if (mbusy) begin
            if (mwait == 0) begin
                bus.mem_ack = 1'b1;
                if (fix_rd_en) bus.mem_rdata = fix_rd;
                mbusy = 1'b0;
            end else begin
                mwait--;
            end
        end
    endtask

    // Check this cycle, step the model, move to the next cycle and react.
    task automatic tick();
        @(negedge clk);
        compare();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.cpu_ack) bus.cpu_req = 1'b0;
        mem_respond();
    endtask

    task automatic wait_ack(input int budget, output int cnt);
        cnt = 0;
        while (!bus.mem_ack && cnt < budget) begin
            tick();
            cnt++;
        end
        if (!bus.mem_ack) check("mem_ack_timeout", 32'(cnt), 32'(budget + 1));
    endtask

    task automatic zero_inputs();
        bus.disp_req = 1'b0; bus.disp_addr = 18'h0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 18'h0;
        bus.cpu_wdata = 16'h0; bus.cpu_wstrb = 2'b00;
        bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        zero_inputs();
        mbusy = 1'b0;
        #1;
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        check("rst_disp_ack", 32'(bus.disp_ack), 32'd0);
        check("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
        check("rst_disp_rdata", 32'(bus.disp_rdata), 32'd0);
        check("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        rst = 1'b1;
        zero_inputs();
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // display read, memory latency 3
        fix_lat = 3; fix_rd_en = 1'b1; fix_rd = 16'hA5A5;
        bus.disp_addr = 18'h00100; bus.disp_req = 1'b1;
        tick();
        bus.disp_req = 1'b0;
        check("dr_mem_req", 32'(bus.mem_req), 32'd1);
        check("dr_mem_addr", 32'(bus.mem_addr), 32'h00100);
        check("dr_mem_we", 32'(bus.mem_we), 32'd0);
        wait_ack(20, n);
        check("dr_latency", 32'(n), 32'd3);
        tick();
        check("dr_disp_ack", 32'(bus.disp_ack), 32'd1);
        check("dr_disp_rdata", 32'(bus.disp_rdata), 32'hA5A5);
        check("dr_mem_req_low", 32'(bus.mem_req), 32'd0);
        tick();
        check("dr_ack_once", 32'(bus.disp_ack), 32'd0);

        // CPU write with high-byte strobe
        fix_rd = 16'hBEEF;
        bus.cpu_we = 1'b1; bus.cpu_addr = 18'h3FFFE; bus.cpu_wdata = 16'h1234;
        bus.cpu_wstrb = 2'b10; bus.cpu_req = 1'b1;
        tick();
        check("cw_mem_we", 32'(bus.mem_we), 32'd1);
        check("cw_mem_addr", 32'(bus.mem_addr), 32'h3FFFE);
        check("cw_mem_wdata", 32'(bus.mem_wdata), 32'h1234);
        check("cw_mem_wstrb", 32'(bus.mem_wstrb), 32'h2);
        wait_ack(20, n);
        tick();
        check("cw_cpu_ack", 32'(bus.cpu_ack), 32'd1);
        check("cw_no_disp_ack", 32'(bus.disp_ack), 32'd0);
        check("cw_rdata_kept", 32'(bus.cpu_rdata), 32'h0);

        // simultaneous first requests: display first, CPU at M+2
        fix_lat = 2;
        bus.disp_addr = 18'h01234; bus.disp_req = 1'b1;
        bus.cpu_we = 1'b0; bus.cpu_addr = 18'h00A0F; bus.cpu_req = 1'b1;
        tick();
        bus.disp_req = 1'b0;
        check("sim_first_addr", 32'(bus.mem_addr), 32'h01234);
        wait_ack(20, n);
        tick();
        check("sim_gap_req", 32'(bus.mem_req), 32'd0);
        check("sim_disp_ack", 32'(bus.disp_ack), 32'd1);
        tick();
        check("sim_cpu_req", 32'(bus.mem_req), 32'd1);
        check("sim_cpu_addr", 32'(bus.mem_addr), 32'h00A0F);
        wait_ack(20, n);
        tick();
        check("sim_cpu_rdata", 32'(bus.cpu_rdata), 32'hBEEF);

        // display pulse coinciding with the CPU's mem_ack
        bus.cpu_we = 1'b1; bus.cpu_addr = 18'h00010; bus.cpu_wdata = 16'hCAFE;
        bus.cpu_wstrb = 2'b01; bus.cpu_req = 1'b1;
        tick();
        wait_ack(20, n);
        bus.disp_addr = 18'h24680; bus.disp_req = 1'b1;
        tick();
        bus.disp_req = 1'b0;
        check("pb_cpu_ack", 32'(bus.cpu_ack), 32'd1);
        tick();
        check("pb_mem_req", 32'(bus.mem_req), 32'd1);
        check("pb_mem_addr", 32'(bus.mem_addr), 32'h24680);
        wait_ack(20, n);
        tick();
        check("pb_disp_rdata", 32'(bus.disp_rdata), 32'hBEEF);

        // starvation guard: 4 display grants, then CPU, then display again
        do_reset();
        fix_lat = 1; fix_rd_en = 1'b0;
        bus.cpu_we = 1'b0; bus.cpu_addr = 18'h01000; bus.cpu_req = 1'b1;
        bus.disp_addr = 18'h00200; bus.disp_req = 1'b1;
        nseq = 0;
        for (int i = 0; i < 300 && nseq < 6; i++) begin
            tick();
            bus.disp_req = 1'b0;
            if (bus.disp_ack) begin
                seq[nseq] = 1; nseq++;
                if (nseq < 6) begin
                    bus.disp_req = 1'b1; bus.disp_addr = bus.disp_addr + 18'd2;
                end
            end else if (bus.cpu_ack) begin
                seq[nseq] = 2; nseq++;
            end
        end
        check("sv_count", 32'(nseq), 32'd6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("sv_order%0d", k), 32'(seq[k]), (k == 4) ? 32'd2 : 32'd1);
        end
        repeat (4) tick();

        // reset mid-transaction, stray ack, then normal traffic
        fix_lat = 8;
        bus.disp_addr = 18'h00333; bus.disp_req = 1'b1;
        tick();
        bus.disp_req = 1'b0;
        tick();
        check("mr_busy", 32'(bus.mem_req), 32'd1);
        do_reset();
        bus.mem_ack = 1'b1; bus.mem_rdata = 16'h7777;
        tick();
        check("mr_no_disp_ack", 32'(bus.disp_ack), 32'd0);
        check("mr_no_cpu_ack", 32'(bus.cpu_ack), 32'd0);
        check("mr_idle", 32'(bus.mem_req), 32'd0);
        fix_lat = 0; fix_rd_en = 1'b1; fix_rd = 16'h5A5A;
        bus.disp_addr = 18'h00222; bus.disp_req = 1'b1;
        tick();
        bus.disp_req = 1'b0;
        check("mr_next_addr", 32'(bus.mem_addr), 32'h00222);
        wait_ack(20, n);
        tick();
        check("mr_next_rdata", 32'(bus.disp_rdata), 32'h5A5A);

        // randomized traffic
        fix_lat = -1; fix_rd_en = 1'b0; d_out = 1'b0;
        repeat (3000) begin
            bus.disp_req = 1'b0;
            if (bus.disp_ack) d_out = 1'b0;
            if (!d_out && $urandom_range(0, 3) != 0) begin
                bus.disp_req = 1'b1; bus.disp_addr = 18'($urandom); d_out = 1'b1;
            end
            if (!bus.cpu_req && $urandom_range(0, 2) == 0) begin
                bus.cpu_we = 1'($urandom); bus.cpu_addr = 18'($urandom);
                bus.cpu_wdata = 16'($urandom); bus.cpu_wstrb = 2'($urandom);
                bus.cpu_req = 1'b1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
